scroll_addr_pipe: RTL and testbench

- Pixel-address stage between the VGA timing controller and the 320x240 picture block RAM.
- Maps 640x480 screen counters to a 2x-downscaled image address, with per-frame wrap-around scrolling and optional horizontal mirroring.
- Delays valid/hsync/vsync to match the address-register plus RAM read latency, so the colour mux receives aligned signals.
- Runs entirely on the 25 MHz pixel clock.

---
 rtl/scroll_addr_pipe_if.sv | 28 ++
 rtl/scroll_addr_pipe.sv | 110 +++++++++++
 tb/tb_scroll_addr_pipe.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/scroll_addr_pipe_if.sv
// Pixel-address stage bus: timing-controller inputs and RAM-side outputs.
// Master drives screen counters and scroll controls; slave returns address and delayed syncs.
interface scroll_addr_pipe_if;
    logic [9:0]  h_cnt;
    logic [9:0]  v_cnt;
    logic        valid_in;
    logic        hsync_in;
    logic        vsync_in;
    logic        en;
    logic [1:0]  dir;
    logic        mirror;
    logic [16:0] pixel_addr;
    logic        valid_out;
    logic        hsync_out;
    logic        vsync_out;

    modport master (
        output h_cnt, v_cnt, valid_in, hsync_in, vsync_in,
        output en, dir, mirror,
        input  pixel_addr, valid_out, hsync_out, vsync_out
    );

    modport slave (
        input  h_cnt, v_cnt, valid_in, hsync_in, vsync_in,
        input  en, dir, mirror,
        output pixel_addr, valid_out, hsync_out, vsync_out
    );
endinterface

// File: rtl/scroll_addr_pipe.sv
// Maps 640x480 screen counters to a 2x-downscaled, scrolled, optionally mirrored
// picture RAM address and delays valid/sync to line up with the RAM output.
module scroll_addr_pipe #(
    parameter int IMG_W     = 320,
    parameter int IMG_H     = 240,
    parameter int V_ACTIVE  = 480,
    parameter int STEP      = 1,
    parameter int FRAME_DIV = 1,
    parameter int PIPE      = 2,
    parameter bit SYNC_IDLE = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    scroll_addr_pipe_if.slave pix
);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_RUN  = 1'b1;

    localparam int             FCW     = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
    localparam logic [FCW-1:0] FC_LAST = FCW'(FRAME_DIV - 1);
    localparam logic [FCW-1:0] FC_ONE  = FCW'(1);
    localparam logic [9:0]     W10     = 10'(IMG_W);
    localparam logic [9:0]     H10     = 10'(IMG_H);
    localparam logic [9:0]     S10     = 10'(STEP);
    localparam logic [9:0]     VA10    = 10'(V_ACTIVE);
    localparam logic [16:0]    W17     = 17'(IMG_W);

    logic [0:0]     state_q, state_d;
    logic [9:0]     hoff_q, hoff_d;
    logic [9:0]     voff_q, voff_d;
    logic [FCW-1:0] fc_q, fc_d, fc_base;
    logic [16:0]    addr_q, addr_d;
    logic           cond_q, cond, tick;
    logic [PIPE-1:0] vld_q, hs_q, vs_q;

    logic [9:0] x, y, xsum, ysum, xs, ys, xm;

    always_comb begin
        x    = pix.h_cnt >> 1;
        y    = pix.v_cnt >> 1;
        xsum = x + hoff_q;
        ysum = y + voff_q;
        xs   = (xsum >= W10) ? xsum - W10 : xsum;
        ys   = (ysum >= H10) ? ysum - H10 : ysum;
        xm   = pix.mirror ? (W10 - 10'd1 - xs) : xs;
        addr_d = pix.valid_in ? ({7'd0, ys} * W17 + {7'd0, xm}) : 17'd0;
    end

    // Tick only on the first cycle of the blanking-start point.
    assign cond = (pix.v_cnt == VA10) && (pix.h_cnt == 10'd0);
    assign tick = cond & ~cond_q;

    always_comb begin
        state_d = pix.en ? S_RUN : S_IDLE;
        hoff_d  = hoff_q;
        voff_d  = voff_q;
        fc_d    = fc_q;
        fc_base = (state_q == S_RUN) ? fc_q : '0;
        if (!pix.en) begin
            fc_d = '0;
        end else if (tick) begin
            if (fc_base == FC_LAST) begin
                fc_d = '0;
                unique case (pix.dir)
                    2'b00: hoff_d = (hoff_q + S10 >= W10) ? hoff_q + S10 - W10
                                                          : hoff_q + S10;
                    2'b01: hoff_d = (hoff_q < S10) ? hoff_q + W10 - S10
                                                   : hoff_q - S10;
                    2'b10: voff_d = (voff_q + S10 >= H10) ? voff_q + S10 - H10
                                                          : voff_q + S10;
                    2'b11: voff_d = (voff_q < S10) ? voff_q + H10 - S10
                                                   : voff_q - S10;
                endcase
            end else begin
                fc_d = fc_base + FC_ONE;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            hoff_q  <= '0;
            voff_q  <= '0;
            fc_q    <= '0;
            addr_q  <= '0;
            cond_q  <= 1'b0;
            vld_q   <= '0;
            hs_q    <= {PIPE{SYNC_IDLE}};
            vs_q    <= {PIPE{SYNC_IDLE}};
        end else begin
            state_q <= state_d;
            hoff_q  <= hoff_d;
            voff_q  <= voff_d;
            fc_q    <= fc_d;
            addr_q  <= addr_d;
            cond_q  <= cond;
            vld_q   <= PIPE'({vld_q, pix.valid_in});
            hs_q    <= PIPE'({hs_q, pix.hsync_in});
            vs_q    <= PIPE'({vs_q, pix.vsync_in});
        end
    end

    assign pix.pixel_addr = addr_q;
    assign pix.valid_out  = vld_q[PIPE-1];
    assign pix.hsync_out  = hs_q[PIPE-1];
    assign pix.vsync_out  = vs_q[PIPE-1];

endmodule

// File: tb/tb_scroll_addr_pipe.sv
// Bench for scroll_addr_pipe: table vectors, scroll sequences and random traffic
// checked against a modulo-arithmetic reference of the scroll/address rules.
module tb_scroll_addr_pipe;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #20 clk = ~clk;

    scroll_addr_pipe_if b1();
    scroll_addr_pipe_if b3();

    assign b3.h_cnt    = b1.h_cnt;
    assign b3.v_cnt    = b1.v_cnt;
    assign b3.valid_in = b1.valid_in;
    assign b3.hsync_in = b1.hsync_in;
    assign b3.vsync_in = b1.vsync_in;
    assign b3.en       = b1.en;
    assign b3.dir      = b1.dir;
    assign b3.mirror   = b1.mirror;

    scroll_addr_pipe dut1 (.clk(clk), .rst(rst), .pix(b1.slave));
    scroll_addr_pipe #(.FRAME_DIV(3)) dut3 (.clk(clk), .rst(rst), .pix(b3.slave));

    int n_cmp = 0;
    int n_bad = 0;

    int hoff_m [2];
    int voff_m [2];
    int fc_m   [2];
    int fdiv   [2] = '{1, 3};
    bit cond_prev;
    logic [2:0] hist1;

    typedef struct {
        int h;
        int v;
        bit val;
        bit m;
        int exp;
    } vec_t;

    task automatic chk(string name, int act, int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int ref_addr(int k, int h, int v, bit val, bit m);
        int xs, ys, xm;
        if (!val) return 0;
        xs = ((h / 2) + hoff_m[k]) % 320;
        ys = ((v / 2) + voff_m[k]) % 240;
        xm = m ? 319 - xs : xs;
        return ys * 320 + xm;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            hoff_m[k] = 0;
            voff_m[k] = 0;
            fc_m[k]   = 0;
        end
        cond_prev = 1'b0;
        hist1     = 3'b011;
    endtask

    task automatic put(int h, int v, bit val, bit hs, bit vs, bit m);
        b1.h_cnt    = 10'(h);
        b1.v_cnt    = 10'(v);
        b1.valid_in = val;
        b1.hsync_in = hs;
        b1.vsync_in = vs;
        b1.mirror   = m;
    endtask

    task automatic cycle();
        int e0, e1;
        bit c;
        logic [2:0] ep;
        e0 = ref_addr(0, int'(b1.h_cnt), int'(b1.v_cnt), b1.valid_in, b1.mirror);
        e1 = ref_addr(1, int'(b1.h_cnt), int'(b1.v_cnt), b1.valid_in, b1.mirror);
        c = (b1.v_cnt == 10'd480) && (b1.h_cnt == 10'd0);
        for (int k = 0; k < 2; k++) begin
            if (!b1.en) fc_m[k] = 0;
            else if (c && !cond_prev) begin
                if (fc_m[k] == fdiv[k] - 1) begin
                    fc_m[k] = 0;
                    case (b1.dir)
                        2'b00: hoff_m[k] = (hoff_m[k] + 1) % 320;
                        2'b01: hoff_m[k] = (hoff_m[k] + 319) % 320;
                        2'b10: voff_m[k] = (voff_m[k] + 1) % 240;
                        default: voff_m[k] = (voff_m[k] + 239) % 240;
                    endcase
                end else begin
                    fc_m[k]++;
                end
            end
        end
        cond_prev = c;
        ep    = hist1;
        hist1 = {b1.valid_in, b1.hsync_in, b1.vsync_in};
        @(posedge clk);
        @(negedge clk);
        chk("addr_div1", int'(b1.pixel_addr), e0);
        chk("addr_div3", int'(b3.pixel_addr), e1);
        chk("valid_out", int'(b1.valid_out), int'(ep[2]));
        chk("hsync_out", int'(b1.hsync_out), int'(ep[1]));
        chk("vsync_out", int'(b1.vsync_out), int'(ep[0]));
    endtask

    task automatic frame_tick();
        put(0, 480, 1'b0, 1'b1, 1'b1, 1'b0);
        cycle();
        put(0, 481, 1'b0, 1'b1, 1'b1, 1'b0);
        cycle();
    endtask

    task automatic probe_origin();
        put(0, 0, 1'b1, 1'b1, 1'b1, 1'b0);
        cycle();
    endtask

    task automatic async_reset(string name);
        #5 rst = 1'b1;
        #1;
        chk({name, "_addr"}, int'(b1.pixel_addr), 0);
        chk({name, "_valid"}, int'(b1.valid_out), 0);
        chk({name, "_hsync"}, int'(b1.hsync_out), 1);
        chk({name, "_vsync"}, int'(b3.vsync_out), 1);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
    endtask

    vec_t tbl [8];

    initial begin
        tbl[0] = '{h: 10,  v: 6,   val: 1'b1, m: 1'b0, exp: 965};
        tbl[1] = '{h: 639, v: 479, val: 1'b1, m: 1'b1, exp: 76480};
        tbl[2] = '{h: 639, v: 479, val: 1'b0, m: 1'b1, exp: 0};
        tbl[3] = '{h: 0,   v: 0,   val: 1'b1, m: 1'b0, exp: 0};
        tbl[4] = '{h: 0,   v: 0,   val: 1'b1, m: 1'b1, exp: 319};
        tbl[5] = '{h: 639, v: 479, val: 1'b1, m: 1'b0, exp: 76799};
        tbl[6] = '{h: 100, v: 200, val: 1'b1, m: 1'b0, exp: 32050};
        tbl[7] = '{h: 3,   v: 1,   val: 1'b1, m: 1'b1, exp: 318};

        put(0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
        b1.en  = 1'b0;
        b1.dir = 2'b00;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        chk("rst_addr", int'(b1.pixel_addr), 0);
        chk("rst_valid", int'(b1.valid_out), 0);
        chk("rst_hsync", int'(b1.hsync_out), 1);
        chk("rst_vsync", int'(b1.vsync_out), 1);
        rst = 1'b0;

        for (int i = 0; i < 8; i++) begin
            put(tbl[i].h, tbl[i].v, tbl[i].val, 1'b0, 1'b1, tbl[i].m);
            cycle();
            chk($sformatf("tbl%0d", i), int'(b1.pixel_addr), tbl[i].exp);
        end

        b1.en  = 1'b1;
        b1.dir = 2'b01;
        frame_tick();
        probe_origin();
        chk("scroll_left", int'(b1.pixel_addr), 319);

        b1.dir = 2'b10;
        for (int i = 0; i < 240; i++) frame_tick();
        probe_origin();
        chk("voff_240", int'(b1.pixel_addr), 319);
        frame_tick();
        probe_origin();
        chk("voff_241", int'(b1.pixel_addr), 320 + 319);

        @(negedge clk);
        async_reset("rst_seq");
        b1.en  = 1'b1;
        b1.dir = 2'b00;
        frame_tick();
        frame_tick();
        probe_origin();
        chk("div3_two_ticks", int'(b3.pixel_addr), 0);
        b1.en = 1'b0;
        probe_origin();
        b1.en = 1'b1;
        probe_origin();
        for (int i = 0; i < 3; i++) frame_tick();
        probe_origin();
        chk("div3_restart", int'(b3.pixel_addr), 1);
        chk("div1_five", int'(b1.pixel_addr), 5);

        for (int i = 0; i < 400; i++) begin
            if (i == 200) async_reset("rst_mid");
            if (i % 37 == 36) begin
                b1.en  = ($urandom_range(0, 7) != 0);
                b1.dir = 2'($urandom_range(0, 3));
                frame_tick();
            end
            put($urandom_range(0, 639), $urandom_range(0, 479),
                1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
            cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
